mem_stage_ws: RTL and testbench
===============================

Name: mem_stage_ws

Overview:
- Parametrised pipeline memory stage: data RAM, MEM/WB pipeline register and branch-resolution output in one block.
- Sits between EX/MEM and the writeback mux.
- Adds over the previous stage:
  - byte/half/word accesses with sign or zero extension
  - configurable memory wait states with a pipeline stall output
  - valid tracking and misaligned-access detection

Parameters:
- ADDR_W, 10, word-address bits; RAM depth is 2**ADDR_W 32-bit words.
- WAIT_CYCLES, 0, extra cycles per load/store; range 0..15.
- WB_CTL_W, 2, width of the writeback control bundle.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  EX/MEM slot holds a real instruction
- address  in  32  byte address; also the ALU result
- write_data  in  32  store data, right-aligned
- memread  in  1  load
- memwrite  in  1  store
- size  in  2  00 byte, 01 half, 10 word, 11 treated as word
- unsigned_ld  in  1  zero-extend sub-word loads
- m_ctlout  in  1  branch instruction
- zero  in  1  ALU zero flag
- write_reg_in  in  5  destination register
- control_wb_in  in  WB_CTL_W  writeback controls
- stall  out  1  hold upstream stages; inputs must stay stable while high
- PCSrc  out  1  take branch
- read_data  out  32  registered, extended load data
- mem_ALU_result  out  32  registered address/ALU result
- mem_control_wb  out  WB_CTL_W  registered controls
- mem_write_reg  out  5  registered destination
- wb_valid  out  1  MEM/WB slot valid
- misalign  out  1  registered; slot had a misaligned access

Behaviour:
- Reset (reset=0, asynchronous):
  - all registered outputs go to 0; the FSM goes to IDLE; the wait counter clears.
  - RAM contents are not cleared.
- Address mapping:
  - word index = address[ADDR_W+1:2]; upper address bits are ignored.
  - byte lane = address[1:0].
- Access condition: access = in_valid & (memread | memwrite) & aligned.
- Alignment rules:
  - a half access requires address[0]=0.
  - a word access requires address[1:0]=00.
  - a byte access is always aligned.
- Misaligned access:
  - no RAM write and no stall.
  - the slot still retires next edge with read_data=0, misalign=1, and control_wb and write_reg passed through.
- memread and memwrite both high: treated as a store; read_data=0.
- Stores are byte-lane masked writes:
  - byte: write_data[7:0] goes to the lane selected by address[1:0].
  - half: write_data[15:0] goes to lanes {1,0} or {3,2}.
  - word: all four lanes.
- Loads select the addressed lane(s), then sign-extend (unsigned_ld=0) or zero-extend.
- FSM states IDLE and WAIT with a 4-bit counter cnt.
- WAIT_CYCLES=0:
  - every access completes at the edge ending the cycle it is presented.
  - stall is constantly 0.
- WAIT_CYCLES=N>0:
  - IDLE with access: stall=1 (combinational). Next edge: go to WAIT with cnt=N-1.
  - WAIT with cnt!=0: stall=1; cnt decrements.
  - WAIT with cnt=0: stall=0. At the edge, the RAM write is performed and the load is captured. Next state is IDLE.
  - Result: stall is high for exactly N consecutive cycles per access, and the access retires N+1 cycles after it is presented.
  - Back-to-back accesses: after retiring, the FSM re-enters the sequence immediately if access is still high.
- While stall=1:
  - the MEM/WB register loads a bubble: wb_valid=0, mem_control_wb=0, misalign=0.
  - read_data, mem_ALU_result and mem_write_reg hold.
  - the RAM is not written.
- Non-memory instruction (in_valid=1, no read/write): retires next edge with read_data=0, wb_valid=1.
- in_valid=0: a bubble is loaded.
- PCSrc = in_valid & m_ctlout & zero, combinational, independent of stall.
- Reset mid-access: the pending store is discarded (RAM unchanged) and the FSM returns to IDLE.

Test Plan:
- WAIT_CYCLES=0: store word 0xDEADBEEF @0x10, then load word @0x10 -> read_data=0xDEADBEEF one edge after the load is presented; wb_valid=1; stall never high.
- Sub-word loads: store byte 0x80 @0x21, then load byte @0x21 -> 0xFFFFFF80. Same load with unsigned_ld=1 -> 0x00000080. Load half @0x20 -> bits [15:8]=0x80.
- WAIT_CYCLES=3: load presented with inputs held -> stall high exactly 3 cycles; wb_valid=0 during those cycles; data appears at the 4th edge. A back-to-back second load stalls 3 more cycles.
- Misaligned half store @0x13 -> RAM @0x10 unchanged; next-cycle misalign=1, wb_valid=1, stall=0.
- Branch: m_ctlout=1, zero=1, in_valid=1 -> PCSrc=1 same cycle. zero=0 -> PCSrc=0. in_valid=0 -> PCSrc=0.
- Reset: assert reset=0 during WAIT of a store with WAIT_CYCLES=2 -> outputs 0 immediately; a later load of that address returns the old value.

Source files
------------

// File: rtl/mem_stage_ws.sv
// mem_stage_ws: pipeline memory stage with a data RAM, a MEM/WB pipeline
// register and branch resolution in one block.
//
// Ports
//   clk, reset (async, active-low)
//   EX/MEM side : in_valid, address, write_data, memread, memwrite, size,
//                 unsigned_ld, m_ctlout, zero, write_reg_in, control_wb_in
//   Control     : stall (hold upstream), PCSrc (take branch, combinational)
//   MEM/WB side : read_data, mem_ALU_result, mem_control_wb, mem_write_reg,
//                 wb_valid, misalign
//   Debug       : dbg_state (1 = WAIT), dbg_cnt (wait counter)
//
// Handshake: an EX/MEM slot is consumed at a rising edge only when
// stall=0. While stall=1 the upstream stages must hold every input
// stable. The MEM/WB slot is valid when wb_valid=1. A memory access
// presented with WAIT_CYCLES=N holds stall high for N cycles and retires
// at the edge after the first stall-free cycle.
module mem_stage_ws #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 0,
  parameter int WB_CTL_W    = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  input  logic [31:0]         address,
  input  logic [31:0]         write_data,
  input  logic                memread,
  input  logic                memwrite,
  input  logic [1:0]          size,
  input  logic                unsigned_ld,
  input  logic                m_ctlout,
  input  logic                zero,
  input  logic [4:0]          write_reg_in,
  input  logic [WB_CTL_W-1:0] control_wb_in,
  output logic                stall,
  output logic                PCSrc,
  output logic [31:0]         read_data,
  output logic [31:0]         mem_ALU_result,
  output logic [WB_CTL_W-1:0] mem_control_wb,
  output logic [4:0]          mem_write_reg,
  output logic                wb_valid,
  output logic                misalign,
  output logic                dbg_state,
  output logic [3:0]          dbg_cnt
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
  localparam int         DEPTH    = 1 << ADDR_W;

  // ---------------------------------------------------------------------
  // Access decode
  // ---------------------------------------------------------------------
  logic [ADDR_W-1:0] word_idx;
  logic [1:0]        lane;
  logic              size_byte;
  logic              size_half;
  logic              aligned;
  logic              mem_op;
  logic              access;
  logic              misal;
  logic              complete;
  logic              ram_we;

  assign word_idx  = address[ADDR_W+1:2];
  assign lane      = address[1:0];
  assign size_byte = (size == 2'b00);
  assign size_half = (size == 2'b01);

  // Size 2'b11 falls into the word rule.
  always_comb begin
    aligned = 1'b1;
    if (size_half)      aligned = ~address[0];
    else if (!size_byte) aligned = (address[1:0] == 2'b00);
  end

  assign mem_op   = in_valid & (memread | memwrite);
  assign access   = mem_op & aligned;
  assign misal    = mem_op & ~aligned;
  assign complete = access & ~stall;
  // Gating with reset keeps a store from landing in the RAM while the
  // stage is held in reset.
  assign ram_we   = complete & memwrite & reset;

  assign PCSrc = in_valid & m_ctlout & zero;

  // ---------------------------------------------------------------------
  // Wait-state FSM
  // ---------------------------------------------------------------------
  state_t     state, state_nx;
  logic [3:0] cnt, cnt_nx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      ST_IDLE: begin
        if (access && (WAIT_CYCLES != 0)) begin
          state_nx = ST_WAIT;
          cnt_nx   = CNT_INIT;
        end
      end
      ST_WAIT: begin
        if (cnt != 4'd0) cnt_nx   = cnt - 4'd1;
        else             state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
        cnt_nx   = 4'd0;
      end
    endcase
  end

  // IDLE contributes one stall cycle and WAIT contributes N-1, giving N.
  always_comb begin
    stall = 1'b0;
    if (WAIT_CYCLES != 0) begin
      unique case (state)
        ST_IDLE: stall = access;
        ST_WAIT: stall = (cnt != 4'd0);
        default: stall = 1'b0;
      endcase
    end
  end

  assign dbg_state = (state == ST_WAIT);
  assign dbg_cnt   = cnt;

  // ---------------------------------------------------------------------
  // Data RAM: byte-lane masked writes, asynchronous read
  // ---------------------------------------------------------------------
  logic [31:0] ram [DEPTH];
  logic [3:0]  byte_en;
  logic [31:0] wdata_rep;

  // Store data is replicated across lanes so the byte enables alone pick
  // the destination lane(s).
  always_comb begin
    if (size_byte) begin
      byte_en   = 4'b0001 << lane;
      wdata_rep = {4{write_data[7:0]}};
    end else if (size_half) begin
      byte_en   = address[1] ? 4'b1100 : 4'b0011;
      wdata_rep = {2{write_data[15:0]}};
    end else begin
      byte_en   = 4'b1111;
      wdata_rep = write_data;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) ram[word_idx][8*b +: 8] <= wdata_rep[8*b +: 8];
      end
    end
  end

  logic [31:0] lane_data;
  logic [31:0] load_ext;

  // Shifting the addressed lane down to bit 0 makes byte and half selection
  // uniform; aligned word loads shift by zero.
  always_comb begin
    lane_data = ram[word_idx] >> {lane, 3'b000};
    if (size_byte)
      load_ext = unsigned_ld ? {24'd0, lane_data[7:0]}
                             : {{24{lane_data[7]}}, lane_data[7:0]};
    else if (size_half)
      load_ext = unsigned_ld ? {16'd0, lane_data[15:0]}
                             : {{16{lane_data[15]}}, lane_data[15:0]};
    else
      load_ext = lane_data;
  end

  // ---------------------------------------------------------------------
  // MEM/WB pipeline register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      read_data      <= 32'd0;
      mem_ALU_result <= 32'd0;
      mem_control_wb <= '0;
      mem_write_reg  <= 5'd0;
      wb_valid       <= 1'b0;
      misalign       <= 1'b0;
    end else if (stall || !in_valid) begin
      // Bubble: only the qualifying fields are cleared, data fields hold.
      wb_valid       <= 1'b0;
      mem_control_wb <= '0;
      misalign       <= 1'b0;
    end else begin
      wb_valid       <= 1'b1;
      mem_control_wb <= control_wb_in;
      mem_write_reg  <= write_reg_in;
      mem_ALU_result <= address;
      misalign       <= misal;
      // Loads only; stores (including read+write) and misaligned slots give 0.
      read_data      <= (access && memread && !memwrite) ? load_ext : 32'd0;
    end
  end

endmodule

// File: tb/tb_mem_stage_ws.sv
module tb_mem_stage_ws;

  localparam int AW = 8;
  localparam int CW = 2;

  typedef struct packed {
    logic          rst;
    logic          in_valid;
    logic [31:0]   address;
    logic [31:0]   write_data;
    logic          memread;
    logic          memwrite;
    logic [1:0]    size;
    logic          unsigned_ld;
    logic          m_ctlout;
    logic          zero;
    logic [4:0]    write_reg;
    logic [CW-1:0] ctl;
  } in_t;

  typedef struct packed {
    logic          stall;
    logic          pcsrc;
    logic [31:0]   read_data;
    logic [31:0]   alu;
    logic [CW-1:0] ctl;
    logic [4:0]    wreg;
    logic          wb_valid;
    logic          misalign;
    logic          dbg_state;
    logic [3:0]    dbg_cnt;
  } out_t;

  typedef struct packed {
    in_t         in;
    logic [31:0] rd;
    logic        mis;
    logic        acc;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  in_t din [3];
  int  total = 0;
  int  bad   = 0;

  // Byte-addressed reference memory per instance (256 words each).
  logic [7:0] mm [3][1024];

  // Instances: 0 -> no wait states, 1 -> 3 wait states, 2 -> 2 wait states.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int WC = (g == 0) ? 0 : (g == 1) ? 3 : 2;
    logic          stall_w, pc_w, val_w, mis_w, st_w;
    logic [31:0]   rd_w, alu_w;
    logic [CW-1:0] ctl_w;
    logic [4:0]    wreg_w;
    logic [3:0]    cnt_w;
    out_t          o;

    mem_stage_ws #(.ADDR_W(AW), .WAIT_CYCLES(WC), .WB_CTL_W(CW)) dut (
      .clk           (clk),
      .reset         (din[g].rst),
      .in_valid      (din[g].in_valid),
      .address       (din[g].address),
      .write_data    (din[g].write_data),
      .memread       (din[g].memread),
      .memwrite      (din[g].memwrite),
      .size          (din[g].size),
      .unsigned_ld   (din[g].unsigned_ld),
      .m_ctlout      (din[g].m_ctlout),
      .zero          (din[g].zero),
      .write_reg_in  (din[g].write_reg),
      .control_wb_in (din[g].ctl),
      .stall         (stall_w),
      .PCSrc         (pc_w),
      .read_data     (rd_w),
      .mem_ALU_result(alu_w),
      .mem_control_wb(ctl_w),
      .mem_write_reg (wreg_w),
      .wb_valid      (val_w),
      .misalign      (mis_w),
      .dbg_state     (st_w),
      .dbg_cnt       (cnt_w)
    );

    assign o = {stall_w, pc_w, rd_w, alu_w, ctl_w, wreg_w, val_w, mis_w, st_w, cnt_w};
  end

  function automatic out_t rd_out(input int k);
    case (k)
      0:       return g_dut[0].o;
      1:       return g_dut[1].o;
      default: return g_dut[2].o;
    endcase
  endfunction

  function automatic int wc(input int k);
    return (k == 0) ? 0 : (k == 1) ? 3 : 2;
  endfunction

  function automatic in_t mk(input logic v, input logic [31:0] a, input logic [31:0] wd,
                             input logic r, input logic w, input logic [1:0] sz,
                             input logic u, input logic br, input logic z);
    in_t t;
    t.rst = 1'b1; t.in_valid = v; t.address = a; t.write_data = wd;
    t.memread = r; t.memwrite = w; t.size = sz; t.unsigned_ld = u;
    t.m_ctlout = br; t.zero = z; t.write_reg = 5'd0; t.ctl = '0;
    return t;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: applies the access rules to the byte memory.
  task automatic model(input int k, input in_t v, output logic [31:0] rd,
                       output logic mis, output logic acc);
    int n, base;
    logic [31:0] val;
    rd = 32'd0; mis = 1'b0; acc = 1'b0;
    if (!v.in_valid || !(v.memread || v.memwrite)) return;
    n = (v.size == 2'b00) ? 1 : (v.size == 2'b01) ? 2 : 4;
    if ((v.address % n) != 0) begin
      mis = 1'b1;
      return;
    end
    acc  = 1'b1;
    base = int'((v.address >> 2) % 256) * 4 + int'(v.address % 4);
    if (v.memwrite) begin
      for (int i = 0; i < n; i++) mm[k][base+i] = v.write_data[8*i +: 8];
    end else begin
      val = 32'd0;
      for (int i = 0; i < n; i++) val = val | (32'(mm[k][base+i]) << (8*i));
      if (!v.unsigned_ld && n < 4 && val[8*n-1]) val = val | (32'hFFFF_FFFF << (8*n));
      rd = val;
    end
  endtask

  // ---------------- driver ----------------
  // Called just after a rising edge. Holds the slot while stall is high and
  // returns the MEM/WB outputs just after the retiring edge.
  task automatic run_txn(input int k, input in_t v, output out_t got,
                         output int stalls, output logic pc);
    out_t first, cur;
    logic done;
    din[k] = v;
    stalls = 0;
    done   = 1'b0;
    first  = '0;
    pc     = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      cur = rd_out(k);
      if (c == 0) pc = cur.pcsrc;
      if (!cur.stall) begin
        done = 1'b1;
        break;
      end
      if (stalls == 0) first = cur;
      else begin
        check("stall_bubble_valid", 32'(cur.wb_valid), 32'd0);
        check("stall_bubble_ctl", 32'(cur.ctl), 32'd0);
        check("stall_bubble_misalign", 32'(cur.misalign), 32'd0);
        check("stall_hold_rd", cur.read_data, first.read_data);
        check("stall_hold_alu", cur.alu, first.alu);
        check("stall_hold_wreg", 32'(cur.wreg), 32'(first.wreg));
      end
      stalls++;
      @(posedge clk); #1;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL stall_timeout: inst %0d stalled %0d cycles, expected %0d", k, stalls, wc(k));
    end
    @(posedge clk); #1;
    got = rd_out(k);
  endtask

  task automatic compare(input string tag, input int k, input in_t v, input out_t got,
                         input int stalls, input logic pc, input logic [31:0] exp_rd,
                         input logic exp_mis, input logic exp_acc);
    check({tag, "_pcsrc"}, 32'(pc), 32'(v.in_valid & v.m_ctlout & v.zero));
    check({tag, "_stalls"}, 32'(stalls), exp_acc ? 32'(wc(k)) : 32'd0);
    check({tag, "_wb_valid"}, 32'(got.wb_valid), 32'(v.in_valid));
    if (v.in_valid) begin
      check({tag, "_misalign"}, 32'(got.misalign), 32'(exp_mis));
      check({tag, "_read_data"}, got.read_data, exp_rd);
      check({tag, "_alu"}, got.alu, v.address);
      check({tag, "_wreg"}, 32'(got.wreg), 32'(v.write_reg));
      check({tag, "_ctl"}, 32'(got.ctl), 32'(v.ctl));
    end else begin
      check({tag, "_ctl"}, 32'(got.ctl), 32'd0);
      check({tag, "_misalign"}, 32'(got.misalign), 32'd0);
    end
  endtask

  function automatic in_t rand_in();
    in_t t;
    int op;
    t.rst         = 1'b1;
    t.in_valid    = ($urandom_range(0, 7) != 0);
    t.address     = $urandom();
    t.write_data  = $urandom();
    t.size        = 2'($urandom_range(0, 3));
    t.unsigned_ld = 1'($urandom_range(0, 1));
    t.m_ctlout    = 1'($urandom_range(0, 1));
    t.zero        = 1'($urandom_range(0, 1));
    t.write_reg   = 5'($urandom_range(0, 31));
    t.ctl         = CW'($urandom_range(0, 3));
    op            = $urandom_range(0, 3);
    t.memread     = (op == 1) || (op == 3);
    t.memwrite    = (op == 2) || (op == 3);
    // Mostly aligned addresses, with a misaligned minority kept.
    if ($urandom_range(0, 3) != 0) begin
      if (t.size == 2'b01) t.address[0] = 1'b0;
      else if (t.size[1]) t.address[1:0] = 2'b00;
    end
    return t;
  endfunction

  // ---------------- main test ----------------
  vec_t tbl[$];

  initial begin
    localparam logic [1:0] B = 2'b00, H = 2'b01, W = 2'b10, X = 2'b11;
    out_t got, cur;
    int   st;
    logic pc;
    logic [31:0] exp_rd;
    logic exp_mis, exp_acc;
    in_t  v;

    tbl.push_back('{mk(1, 32'h10, 32'hDEADBEEF, 0, 1, W, 0, 0, 0), 32'h0, 1'b0, 1'b1});
    tbl.push_back('{mk(1, 32'h10, 32'h0, 1, 0, W, 0, 1, 1), 32'hDEADBEEF, 1'b0, 1'b1});
    tbl.push_back('{mk(1, 32'h20, 32'h0, 0, 1, W, 0, 1, 0), 32'h0, 1'b0, 1'b1});
    tbl.push_back('{mk(1, 32'h21, 32'h12345680, 0, 1, B, 0, 0, 1), 32'h0, 1'b0, 1'b1});
    tbl.push_back('{mk(1, 32'h21, 32'h0, 1, 0, B, 0, 0, 0), 32'hFFFFFF80, 1'b0, 1'b1});
    tbl.push_back('{mk(1, 32'h21, 32'h0, 1, 0, B, 1, 0, 0), 32'h00000080, 1'b0, 1'b1});
    tbl.push_back('{mk(1, 32'h20, 32'h0, 1, 0, H, 0, 0, 0), 32'hFFFF8000, 1'b0, 1'b1});
    tbl.push_back('{mk(1, 32'h20, 32'h0, 1, 0, H, 1, 0, 0), 32'h00008000, 1'b0, 1'b1});
    tbl.push_back('{mk(1, 32'h20, 32'h0, 1, 0, W, 0, 0, 0), 32'h00008000, 1'b0, 1'b1});
    tbl.push_back('{mk(1, 32'h13, 32'h0000AAAA, 0, 1, H, 0, 0, 0), 32'h0, 1'b1, 1'b0});
    tbl.push_back('{mk(1, 32'h10, 32'h0, 1, 0, W, 0, 0, 0), 32'hDEADBEEF, 1'b0, 1'b1});
    tbl.push_back('{mk(1, 32'h12, 32'h0, 1, 0, W, 0, 0, 0), 32'h0, 1'b1, 1'b0});
    tbl.push_back('{mk(1, 32'h30, 32'h11223344, 1, 1, W, 0, 0, 0), 32'h0, 1'b0, 1'b1});
    tbl.push_back('{mk(1, 32'h30, 32'h0, 1, 0, W, 0, 0, 0), 32'h11223344, 1'b0, 1'b1});
    tbl.push_back('{mk(1, 32'h55, 32'h0, 0, 0, W, 0, 1, 1), 32'h0, 1'b0, 1'b0});
    tbl.push_back('{mk(0, 32'h10, 32'h0, 1, 0, W, 0, 1, 1), 32'h0, 1'b0, 1'b0});
    tbl.push_back('{mk(1, 32'h40, 32'hCAFEF00D, 0, 1, X, 0, 0, 0), 32'h0, 1'b0, 1'b1});
    tbl.push_back('{mk(1, 32'h40, 32'h0, 1, 0, X, 0, 0, 0), 32'hCAFEF00D, 1'b0, 1'b1});
    tbl.push_back('{mk(1, 32'h42, 32'h5555BEEF, 0, 1, H, 0, 0, 0), 32'h0, 1'b0, 1'b1});
    tbl.push_back('{mk(1, 32'h40, 32'h0, 1, 0, W, 0, 0, 0), 32'hBEEFF00D, 1'b0, 1'b1});
    tbl.push_back('{mk(1, 32'h42, 32'h0, 1, 0, H, 1, 0, 0), 32'h0000BEEF, 1'b0, 1'b1});
    tbl.push_back('{mk(1, 32'h42, 32'h0, 1, 0, H, 0, 0, 0), 32'hFFFFBEEF, 1'b0, 1'b1});
    tbl.push_back('{mk(1, 32'h43, 32'h0, 1, 0, B, 1, 0, 0), 32'h000000BE, 1'b0, 1'b1});
    tbl.push_back('{mk(1, 32'h12345010, 32'h0, 1, 0, W, 0, 0, 0), 32'hDEADBEEF, 1'b0, 1'b1});
    tbl.push_back('{mk(1, 32'h13, 32'h0, 1, 0, B, 1, 0, 0), 32'h000000DE, 1'b0, 1'b1});

    // Reset state of every instance.
    for (int k = 0; k < 3; k++) din[k] = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      cur = rd_out(k);
      check($sformatf("reset%0d_wb_valid", k), 32'(cur.wb_valid), 32'd0);
      check($sformatf("reset%0d_read_data", k), cur.read_data, 32'd0);
      check($sformatf("reset%0d_alu", k), cur.alu, 32'd0);
      check($sformatf("reset%0d_misalign", k), 32'(cur.misalign), 32'd0);
      check($sformatf("reset%0d_stall", k), 32'(cur.stall), 32'd0);
      check($sformatf("reset%0d_state", k), {cur.dbg_state, 27'd0, cur.dbg_cnt}, 32'd0);
    end
    for (int k = 0; k < 3; k++) din[k].rst = 1'b1;
    @(posedge clk); #1;

    // Directed table on the zero-wait and three-wait instances.
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < tbl.size(); i++) begin
        v           = tbl[i].in;
        v.write_reg = 5'(i + 1);
        v.ctl       = CW'(i % 3 + 1);
        run_txn(k, v, got, st, pc);
        compare($sformatf("tbl%0d_inst%0d", i, k), k, v, got, st, pc,
                tbl[i].rd, tbl[i].mis, tbl[i].acc);
      end
      din[k].in_valid = 1'b0;
    end

    // Reset during the WAIT phase of a store (two wait states).
    v = mk(1, 32'h50, 32'h01020304, 0, 1, W, 0, 0, 0);
    v.write_reg = 5'd7;
    v.ctl       = CW'(3);
    run_txn(2, v, got, st, pc);
    compare("rst_first_store", 2, v, got, st, pc, 32'h0, 1'b0, 1'b1);
    din[2] = mk(1, 32'h50, 32'hFFFFFFFF, 0, 1, W, 0, 0, 0);
    @(negedge clk);
    check("rst_pre_stall", 32'(rd_out(2).stall), 32'd1);
    @(posedge clk);
    @(negedge clk);
    check("rst_in_wait", 32'(rd_out(2).dbg_state), 32'd1);
    din[2].rst = 1'b0;
    #1;
    cur = rd_out(2);
    check("rst_async_alu", cur.alu, 32'd0);
    check("rst_async_wreg", 32'(cur.wreg), 32'd0);
    check("rst_async_valid", 32'(cur.wb_valid), 32'd0);
    check("rst_async_state", {cur.dbg_state, 27'd0, cur.dbg_cnt}, 32'd0);
    @(posedge clk); #1;
    din[2].in_valid = 1'b0;
    @(posedge clk); #1;
    din[2].rst = 1'b1;
    @(posedge clk); #1;
    v = mk(1, 32'h50, 32'h0, 1, 0, W, 0, 0, 0);
    run_txn(2, v, got, st, pc);
    compare("rst_reload", 2, v, got, st, pc, 32'h01020304, 1'b0, 1'b1);
    din[2].in_valid = 1'b0;

    // Randomized traffic against the reference model, after filling RAM.
    for (int k = 0; k < 2; k++) begin
      for (int w = 0; w < 256; w++) begin
        v = mk(1, 32'(w * 4), $urandom(), 0, 1, W, 0, 0, 0);
        v.write_reg = 5'($urandom_range(0, 31));
        model(k, v, exp_rd, exp_mis, exp_acc);
        run_txn(k, v, got, st, pc);
        compare($sformatf("fill%0d", k), k, v, got, st, pc, exp_rd, exp_mis, exp_acc);
      end
      for (int n = 0; n < ((k == 0) ? 300 : 120); n++) begin
        v = rand_in();
        model(k, v, exp_rd, exp_mis, exp_acc);
        run_txn(k, v, got, st, pc);
        compare($sformatf("rand%0d_%0d", k, n), k, v, got, st, pc, exp_rd, exp_mis, exp_acc);
      end
      din[k].in_valid = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
